multdiv_iter: RTL and testbench

- Iterative multiply/divide execution unit.
- Sits directly downstream of the multiply/HILO reservation station.
- Takes the op and operands the station holds once they are ready, computes the 64-bit {HI,LO} result or the 32-bit MUL word, and holds it until the station acknowledges.
- Covers MULT/MULTU/MUL/MADD/MADDU/MSUB/MSUBU (fixed 3-cycle) and DIV/DIVU (34-cycle radix-2).

---
 rtl/multdiv_iter_pkg.sv | 35 +++
 rtl/div_iter_core.sv | 66 ++++++
 rtl/multdiv_iter.sv | 157 +++++++++++++++
 tb/tb_multdiv_iter.sv | 161 ++++++++++++++++
 4 files changed

// File: rtl/multdiv_iter_pkg.sv
// Shared definitions for the iterative multiply/divide unit.
// Holds the decoded operation type, the unit's state encoding, the fixed
// latencies seen by the reservation station, and op-class helpers.
package multdiv_iter_pkg;

    localparam int MULT_LATENCY = 3;
    localparam int DIV_LATENCY  = 34;

    typedef enum logic [3:0] {
        OP_NOP, OP_MULT, OP_MULTU, OP_MUL, OP_MADD, OP_MADDU, OP_MSUB,
        OP_MSUBU, OP_DIV, OP_DIVU, OP_MFHI, OP_MFLO, OP_MTHI, OP_MTLO
    } oper_t;

    typedef enum logic [2:0] {
        IDLE, MUL1, MUL2, DIV, FIX, DONE
    } multdiv_state_t;

    function automatic logic is_multdiv_op(oper_t op);
        case (op)
            OP_MULT, OP_MULTU, OP_MUL, OP_MADD, OP_MADDU,
            OP_MSUB, OP_MSUBU, OP_DIV, OP_DIVU: return 1'b1;
            default:                            return 1'b0;
        endcase
    endfunction

    function automatic logic is_div_op(oper_t op);
        return (op == OP_DIV) || (op == OP_DIVU);
    endfunction

    // Signed multiply flavours; OP_DIV is handled separately.
    function automatic logic is_signed_mult(oper_t op);
        return (op == OP_MULT) || (op == OP_MUL) || (op == OP_MADD) || (op == OP_MSUB);
    endfunction

endpackage

// File: rtl/div_iter_core.sv
// Unsigned radix-2 restoring divider, one quotient bit per clock.
// Ports: start loads operands and arms the counter at W-1; abort kills a
// running division; busy is high while iterating; quot/rem are valid the
// cycle after the iteration with count==0; count is the iteration counter.
module div_iter_core #(
    parameter int W  = 32,
    parameter int CW = $clog2(W)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          abort,
    input  logic [W-1:0]  dividend,
    input  logic [W-1:0]  divisor,
    output logic          busy,
    output logic [W-1:0]  quot,
    output logic [W-1:0]  rem,
    output logic [CW-1:0] count
);

    logic [W-1:0]  quot_q, rem_q, dvsr_q;
    logic [CW-1:0] cnt_q;
    logic          busy_q;
    logic [W:0]    part, diff;

    // Shift the next dividend bit into the partial remainder and trial-subtract.
    // The quotient register doubles as the dividend shift register.
    always_comb begin
        part = {rem_q, quot_q[W-1]};
        diff = part - {1'b0, dvsr_q};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            quot_q <= '0;
            rem_q  <= '0;
            dvsr_q <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
        end else if (abort) begin
            busy_q <= 1'b0;
        end else if (start) begin
            quot_q <= dividend;
            rem_q  <= '0;
            dvsr_q <= divisor;
            cnt_q  <= CW'(W - 1);
            busy_q <= 1'b1;
        end else if (busy_q) begin
            if (!diff[W]) begin
                rem_q  <= diff[W-1:0];
                quot_q <= {quot_q[W-2:0], 1'b1};
            end else begin
                rem_q  <= part[W-1:0];
                quot_q <= {quot_q[W-2:0], 1'b0};
            end
            if (cnt_q == '0) busy_q <= 1'b0;
            else             cnt_q  <= cnt_q - 1'b1;
        end
    end

    assign busy  = busy_q;
    assign quot  = quot_q;
    assign rem   = rem_q;
    assign count = cnt_q;

endmodule

// File: rtl/multdiv_iter.sv
// Iterative multiply/divide execution unit behind the HILO reservation station.
// Ports: clk/rst_n clock and async active-low reset; flush aborts to idle;
// req/op/reg1/reg2/hilo carry a ready station entry; ack retires the result;
// ret is the {HI,LO} result, mult_word the MUL GPR result, is_busy is high
// while a multdiv request is presented and its result is not yet ready.
module multdiv_iter
    import multdiv_iter_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    flush,
    input  logic                    req,
    input  oper_t                   op,
    input  logic [DATA_WIDTH-1:0]   reg1,
    input  logic [DATA_WIDTH-1:0]   reg2,
    input  logic [2*DATA_WIDTH-1:0] hilo,
    input  logic                    ack,
    output logic [2*DATA_WIDTH-1:0] ret,
    output logic [DATA_WIDTH-1:0]   mult_word,
    output logic                    is_busy
);

    localparam int DW = DATA_WIDTH;
    localparam int CW = $clog2(DW);

    multdiv_state_t  state_q, state_d;
    oper_t           op_q, op_d;
    logic [DW-1:0]   a_q, a_d, b_q, b_d, mw_q, mw_d;
    logic [2*DW-1:0] hilo_q, hilo_d, prod_q, prod_d, ret_q, ret_d;

    logic [2*DW-1:0] a_ext, b_ext;
    logic [DW-1:0]   a_abs, b_abs, quot_s, rem_s;
    logic            sdiv_in, sdiv_q;
    logic            div_start, div_abort, div_busy;
    logic [DW-1:0]   div_quot, div_rem;
    logic [CW-1:0]   div_cnt;

    // Operands are made non-negative before entering the unsigned core.
    assign sdiv_in = (op == OP_DIV);
    assign a_abs   = (sdiv_in && reg1[DW-1]) ? -reg1 : reg1;
    assign b_abs   = (sdiv_in && reg2[DW-1]) ? -reg2 : reg2;

    assign a_ext = is_signed_mult(op_q) ? {{DW{a_q[DW-1]}}, a_q} : {{DW{1'b0}}, a_q};
    assign b_ext = is_signed_mult(op_q) ? {{DW{b_q[DW-1]}}, b_q} : {{DW{1'b0}}, b_q};

    // Quotient is negative when operand signs differ; remainder follows the dividend.
    assign sdiv_q = (op_q == OP_DIV);
    assign quot_s = (sdiv_q && (a_q[DW-1] ^ b_q[DW-1])) ? -div_quot : div_quot;
    assign rem_s  = (sdiv_q && a_q[DW-1]) ? -div_rem : div_rem;

    // A dropped request aborts just like a flush, so the core is killed on both.
    assign div_abort = flush | ~req;

    assign is_busy = req && (state_q != DONE) && is_multdiv_op(op);

    div_iter_core #(.W(DW)) u_div (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (div_start),
        .abort    (div_abort),
        .dividend (a_abs),
        .divisor  (b_abs),
        .busy     (div_busy),
        .quot     (div_quot),
        .rem      (div_rem),
        .count    (div_cnt)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            op_q    <= OP_NOP;
            a_q     <= '0;
            b_q     <= '0;
            hilo_q  <= '0;
            prod_q  <= '0;
            ret_q   <= '0;
            mw_q    <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            hilo_q  <= hilo_d;
            prod_q  <= prod_d;
            ret_q   <= ret_d;
            mw_q    <= mw_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        a_d       = a_q;
        b_d       = b_q;
        hilo_d    = hilo_q;
        prod_d    = prod_q;
        ret_d     = ret_q;
        mw_d      = mw_q;
        div_start = 1'b0;
        if (flush) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: if (req && is_multdiv_op(op)) begin
                    op_d   = op;
                    a_d    = reg1;
                    b_d    = reg2;
                    hilo_d = hilo;
                    if (!is_div_op(op)) begin
                        state_d = MUL1;
                    end else if (reg2 == '0) begin
                        // Divide by zero leaves HI/LO unchanged.
                        ret_d   = hilo;
                        state_d = DONE;
                    end else begin
                        div_start = 1'b1;
                        state_d   = DIV;
                    end
                end
                MUL1: if (!req) state_d = IDLE;
                      else begin
                          prod_d  = a_ext * b_ext;
                          state_d = MUL2;
                      end
                MUL2: if (!req) state_d = IDLE;
                      else begin
                          case (op_q)
                              OP_MADD, OP_MADDU: ret_d = hilo_q + prod_q;
                              OP_MSUB, OP_MSUBU: ret_d = hilo_q - prod_q;
                              OP_MUL: begin
                                  ret_d = hilo_q;
                                  mw_d  = prod_q[DW-1:0];
                              end
                              default:           ret_d = prod_q;
                          endcase
                          state_d = DONE;
                      end
                DIV:  if (!req) state_d = IDLE;
                      else if (div_cnt == '0 || !div_busy) state_d = FIX;
                FIX:  if (!req) state_d = IDLE;
                      else begin
                          ret_d   = {rem_s, quot_s};
                          state_d = DONE;
                      end
                DONE: if (ack) state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    assign ret       = ret_q;
    assign mult_word = mw_q;

endmodule

// File: tb/tb_multdiv_iter.sv
// Directed bench for multdiv_iter: hand-computed results, busy/latency
// profile, flush, request drop, reset mid-divide and ack/flush collisions.
module tb_multdiv_iter;
    import multdiv_iter_pkg::*;

    logic        clk = 1'b0, rst_n = 1'b1, flush = 1'b0, req = 1'b0, ack = 1'b0;
    oper_t       op = OP_NOP;
    logic [31:0] reg1 = '0, reg2 = '0;
    logic [63:0] hilo = '0;
    logic [63:0] ret;
    logic [31:0] mult_word;
    logic        is_busy;
    int          checks = 0, errors = 0;

    always #5 clk = ~clk;

    multdiv_iter #(.DATA_WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .req(req), .op(op),
        .reg1(reg1), .reg2(reg2), .hilo(hilo), .ack(ack),
        .ret(ret), .mult_word(mult_word), .is_busy(is_busy)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_state(input string tag, input multdiv_state_t s);
        check(tag, 64'(dut.state_q), 64'(s));
    endtask

    // Present one op at the start of a cycle and follow it to DONE and retirement.
    task automatic do_op(input string nm, input oper_t o, input logic [31:0] a, input logic [31:0] b,
                         input logic [63:0] h, input int lat, input logic [63:0] er,
                         input logic [31:0] emw, input bit cmw, input bit early_ack, input int hold);
        req = 1'b1; op = o; reg1 = a; reg2 = b; hilo = h;
        for (int c = 0; c <= lat; c++) begin
            ack = early_ack && (c > 0) && (c < lat);
            #1;
            check($sformatf("%s busy c%0d", nm, c), {63'd0, is_busy}, (c < lat) ? 64'd1 : 64'd0);
            if (c < lat) begin
                step();
                hilo = ~h;   // operands must have been latched at accept
            end
        end
        check({nm, " ret"}, ret, er);
        if (cmw) check({nm, " mword"}, {32'd0, mult_word}, {32'd0, emw});
        for (int k = 0; k < hold; k++) begin
            step(); #1;
            check($sformatf("%s hold busy %0d", nm, k), {63'd0, is_busy}, 64'd0);
            check($sformatf("%s hold ret %0d", nm, k), ret, er);
        end
        chk_state({nm, " done st"}, DONE);
        ack = 1'b1;
        step();
        req = 1'b0; ack = 1'b0; op = OP_NOP;
        #1;
        chk_state({nm, " idle st"}, IDLE);
    endtask

    initial begin
        #2 rst_n = 1'b0;
        #1;
        check("rst ret", ret, 64'd0);
        check("rst mword", {32'd0, mult_word}, 64'd0);
        check("rst busy", {63'd0, is_busy}, 64'd0);
        chk_state("rst st", IDLE);
        step(); step();
        rst_n = 1'b1;
        step();

        do_op("mult", OP_MULT, 32'hFFFFFFFE, 32'd3, 64'd0, MULT_LATENCY,
              64'hFFFFFFFF_FFFFFFFA, 32'd0, 1'b1, 1'b0, 0);
        do_op("maddu", OP_MADDU, 32'h00010000, 32'h00010000, 64'h00000000_FFFFFFFF, MULT_LATENCY,
              64'h00000001_FFFFFFFF, 32'd0, 1'b0, 1'b1, 0);
        do_op("mul", OP_MUL, 32'd7, 32'hFFFFFFFB, 64'h12345678_9ABCDEF0, MULT_LATENCY,
              64'h12345678_9ABCDEF0, 32'hFFFFFFDD, 1'b1, 1'b0, 4);
        do_op("msub", OP_MSUB, 32'd2, 32'd3, 64'd0, MULT_LATENCY,
              64'hFFFFFFFF_FFFFFFFA, 32'hFFFFFFDD, 1'b1, 1'b0, 0);
        do_op("msubu", OP_MSUBU, 32'd1, 32'd3, 64'd10, MULT_LATENCY,
              64'd7, 32'd0, 1'b0, 1'b0, 0);
        do_op("div neg", OP_DIV, 32'hFFFFFFF9, 32'd2, 64'd0, DIV_LATENCY,
              64'hFFFFFFFF_FFFFFFFD, 32'd0, 1'b0, 1'b0, 0);
        do_op("divu", OP_DIVU, 32'hFFFFFFFF, 32'h10, 64'd0, DIV_LATENCY,
              64'h0000000F_0FFFFFFF, 32'd0, 1'b0, 1'b0, 0);
        do_op("div ovf", OP_DIV, 32'h80000000, 32'hFFFFFFFF, 64'd0, DIV_LATENCY,
              64'h00000000_80000000, 32'd0, 1'b0, 1'b0, 0);
        do_op("div0", OP_DIV, 32'd5, 32'd0, 64'hAAAA5555_00001111, 1,
              64'hAAAA5555_00001111, 32'd0, 1'b0, 1'b0, 0);

        // Non-multdiv op: never busy, never leaves IDLE.
        req = 1'b1; op = OP_MFHI;
        #1 check("mfhi busy", {63'd0, is_busy}, 64'd0);
        step();
        chk_state("mfhi st", IDLE);
        req = 1'b0; op = OP_NOP;
        step();

        // Request dropped in MUL1 aborts to IDLE.
        req = 1'b1; op = OP_MULT; reg1 = 32'd4; reg2 = 32'd4;
        step();
        req = 1'b0;
        step();
        chk_state("reqdrop st", IDLE);

        // Flush at divide cycle 10, then a fresh MULTU right behind it.
        req = 1'b1; op = OP_DIV; reg1 = 32'd100; reg2 = 32'd7;
        repeat (10) step();
        chk_state("pre-flush st", DIV);
        flush = 1'b1;
        step();
        flush = 1'b0;
        do_op("multu post-flush", OP_MULTU, 32'd2, 32'd3, 64'd0, MULT_LATENCY,
              64'd6, 32'd0, 1'b0, 1'b0, 0);

        // Async reset mid-divide.
        req = 1'b1; op = OP_DIV; reg1 = 32'd100; reg2 = 32'd7;
        repeat (5) step();
        rst_n = 1'b0; req = 1'b0; op = OP_NOP;
        #1;
        chk_state("rst mid st", IDLE);
        check("rst mid busy", {63'd0, is_busy}, 64'd0);
        check("rst mid ret", ret, 64'd0);
        step();
        rst_n = 1'b1;
        step();
        do_op("divu post-rst", OP_DIVU, 32'd100, 32'd7, 64'd0, DIV_LATENCY,
              64'h00000002_0000000E, 32'd0, 1'b0, 1'b0, 0);

        // ack and flush together in DONE: back to IDLE, no second accept.
        req = 1'b1; op = OP_MULT; reg1 = 32'd5; reg2 = 32'd6;
        repeat (3) step();
        check("ackflush ret", ret, 64'd30);
        chk_state("ackflush done", DONE);
        ack = 1'b1; flush = 1'b1;
        step();
        ack = 1'b0; flush = 1'b0; req = 1'b0; op = OP_NOP;
        #1 chk_state("ackflush st0", IDLE);
        step();
        chk_state("ackflush st1", IDLE);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Hard bound so the run always ends.
    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
